// File: rtl/extmem_ctrl.sv
// Purpose: bridges a single-request bus to a word-addressed external SRAM-style memory; timeout via EXTMEM_CTRL_TIMEOUT_EN.
// Latency: req sample -> ack is MIN_WAIT+1 cycles with done high; a bad address acks on the next cycle.
// Backpressure: the memory stalls with done=0; busy=1 while an access runs, and req is only sampled in IDLE.
module extmem_ctrl #(
    parameter int MIN_WAIT = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic        req,
    input  logic        rw,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        err,
    output logic [17:0] adr,
    inout  wire  [31:0] data,
    output logic [3:0]  byteen,
    output logic        rwb,
    output logic        en,
    input  logic        done
);

    localparam logic [7:0] WAIT_LAST = 8'(MIN_WAIT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, state_nx;
    logic [7:0]  cnt;
    logic        rw_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        err_q;
    logic        bad_addr;
    logic        exit_ok;
    logic        tmo_hit;

    // Only the low 1 MB is backed by the 18-bit word address.
    assign bad_addr = (addr[31:20] != 12'h000);
    assign exit_ok  = done && (cnt >= WAIT_LAST);

`ifdef EXTMEM_CTRL_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    assign tmo_hit = (cnt >= TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; a normal completion takes priority over a timeout on the same edge.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = bad_addr ? DONE : ACCESS;
            ACCESS:  if (exit_ok || tmo_hit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request latch, wait counter, read capture and error flag.
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            cnt     <= 8'd0;
            adr     <= 18'd0;
            rw_q    <= 1'b1;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            err_q   <= 1'b0;
            rdata   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        adr     <= addr[19:2];
                        rw_q    <= rw;
                        wdata_q <= wdata;
                        be_q    <= be;
                        cnt     <= 8'd0;
                        err_q   <= bad_addr;
                    end
                end
                ACCESS: begin
                    if (cnt != 8'hFF) cnt <= cnt + 8'd1;
                    if (exit_ok) begin
                        if (rw_q) rdata <= data;
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory strobes are idle outside ACCESS because the memory writes on every edge with rwb=0.
    always_comb begin
        ack    = (state == DONE);
        err    = (state == DONE) && err_q;
        busy   = (state != IDLE);
        en     = (state == ACCESS);
        rwb    = (state == ACCESS) ? rw_q : 1'b1;
        byteen = ((state == ACCESS) && !rw_q) ? be_q : 4'b0000;
    end

    assign data = ((state == ACCESS) && !rw_q) ? wdata_q : 32'bz;

endmodule

// File: doc/extmem_ctrl.md
EXTMEM_CTRL -- requirements
Module: extmem_ctrl

Interface
REQ-001 SHALL have parameter MIN_WAIT, default 2: minimum cycles en is held per access (legal range 1..15).
REQ-002 SHALL have parameter TIMEOUT, default 255: ACCESS-cycle limit when timeout is compiled in (legal range MIN_WAIT..255).
REQ-003 SHALL have one clock and an asynchronous, active-high reset: ph1 input 1 (clock, rising edge), then reset input 1 (async, active-high).
REQ-004 SHALL have the requester ports:
- req input 1: access request
- rw input 1: 1 = read, 0 = write
- addr input 32: byte address
- wdata input 32: write data
- be input 4: byte enables, bit0 = data[7:0] (little endian)
- ack output 1: one-cycle completion pulse
- rdata output 32: read data
- busy output 1: request in progress
- err output 1: error flag, valid with ack
REQ-005 SHALL have the memory ports:
- adr output 18: word address
- data inout 32: memory data bus
- byteen output 4: memory byte enables
- rwb output 1: 1 = read, 0 = write
- en output 1: access enable
- done input 1: memory completion

Function
REQ-006 SHALL implement three states: IDLE, ACCESS and DONE.
REQ-007 In IDLE, req=1 SHALL latch the following and then enter ACCESS with cycle counter cnt=0:
- addr[19:2] into adr
- rw, wdata and be
REQ-008 In IDLE with req=1 and addr[31:20]!=0, SHALL skip ACCESS, enter DONE with err=1, leave rdata unchanged, and keep rwb=1 and en=0.
REQ-009 In ACCESS, en=1 and rwb SHALL equal the latched rw; byteen SHALL equal the latched be on writes and 4'b0000 on reads.
REQ-010 Outside ACCESS, rwb=1, en=0 and byteen=0, because the memory writes on every clock edge at which rwb=0.
REQ-011 SHALL drive data with latched wdata only in ACCESS with rw=0; at all other times data SHALL be high-impedance.
REQ-012 cnt SHALL increment in each ACCESS cycle and saturate at 255.
REQ-013 SHALL leave ACCESS for DONE at the first edge where done=1 and cnt>=MIN_WAIT-1; for MIN_WAIT=2 with done tied high, en is therefore high for exactly 2 cycles.
REQ-014 On a read, rdata SHALL capture data at the ACCESS->DONE edge and hold that value until the next completed read.
REQ-015 DONE SHALL last exactly one cycle with ack=1, then return to IDLE.
REQ-016 err SHALL be valid only while ack=1 and SHALL be 0 otherwise.
REQ-017 busy SHALL be 1 in ACCESS and DONE, and 0 in IDLE.
REQ-018 req SHALL be sampled only in IDLE; req held through DONE SHALL start a new access on the cycle after ack, giving a 1-cycle IDLE gap.
REQ-019 Changes to addr, wdata, be or rw while busy=1 SHALL have no effect on the access in progress.
REQ-020 Read latency from the req sampling edge to ack SHALL be MIN_WAIT+1 cycles when done is already high.

Reset
REQ-021 While reset=1, outputs SHALL be:
- state=IDLE, cnt=0
- ack=0, busy=0, err=0
- rdata=0, adr=0, byteen=0
- rwb=1, en=0, data high-impedance
REQ-022 Reset asserted during ACCESS SHALL abort the access immediately with no ack; a write aborted before its first clock edge SHALL not reach memory.

Configuration
REQ-023 Macro EXTMEM_CTRL_TIMEOUT_EN SHALL control the timeout feature as follows:
- Defined: if the ACCESS exit condition is not met by the end of ACCESS cycle TIMEOUT (cnt=TIMEOUT-1), the next edge SHALL enter DONE with err=1 and no rdata update.
- Undefined: ACCESS SHALL wait for done indefinitely, and err SHALL be set only by REQ-008.

Verification
REQ-024 Read: done tied 1, memory word 0x10 = 0xCAFEF00D, req=1, rw=1, addr=0x40 -> en high 2 cycles with adr=0x10; ack 3 cycles after the sampling edge; rdata=0xCAFEF00D; err=0.
REQ-025 Partial write: req with rw=0, addr=0x80, wdata=0x11223344, be=4'b0010, word 0x20 initially 0xAAAAAAAA -> data driven only in ACCESS; word 0x20 becomes 0xAAAA33AA; rwb=1 in every non-ACCESS cycle.
REQ-026 Bad address: req with addr=0x00100000 -> en never asserts; ack with err=1 one cycle after the sampling edge; rdata unchanged.
REQ-027 Back-to-back and hold: req held high for two reads while done is held low for 5 ACCESS cycles -> en held until done rises; two acks separated by one IDLE cycle; addr change mid-access ignored.
REQ-028 Reset and timeout: reset pulsed mid-ACCESS -> en=0, rwb=1, busy=0 immediately and no ack. With EXTMEM_CTRL_TIMEOUT_EN defined, TIMEOUT=8 and done=0 -> ack with err=1 after 8 ACCESS cycles.
